// File: rtl/inst_fetcher.sv
// inst_fetcher: fetch stage holding the PC, with a direct-mapped one-word-line instruction cache
module inst_fetcher #(
  parameter int ICACHE_INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic [31:0] pc_to_mem_ctrl,
  output logic        start_query_signal,
  input  logic        finish_query_signal,
  input  logic [31:0] inst_from_mem_ctrl,
  input  logic        stall_from_dispatch,
  output logic        inst_valid_to_dispatch,
  output logic [31:0] inst_to_dispatch,
  output logic [31:0] pc_to_dispatch,
  input  logic        clear_signal_from_rob,
  input  logic [31:0] target_pc_from_rob
);
  localparam int N = 1 << ICACHE_INDEX_BITS;
  localparam int TW = 30 - ICACHE_INDEX_BITS;
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d, inst_q, inst_d, dpc_q, dpc_d;
  logic start_q, start_d, ivalid_q, ivalid_d;
  logic [N-1:0] valid_q;
  logic [TW-1:0] tag_q [N];
  logic [31:0] data_q [N];
  logic [ICACHE_INDEX_BITS-1:0] idx, fill_idx;
  logic hit, fill;
  assign idx = pc_q[ICACHE_INDEX_BITS+1:2];
  assign fill_idx = req_pc_q[ICACHE_INDEX_BITS+1:2];
  assign hit = valid_q[idx] && tag_q[idx] == pc_q[31:ICACHE_INDEX_BITS+2];
  assign fill = state_q == WAIT_MEM && finish_query_signal;
  assign pc_to_mem_ctrl = req_pc_q;
  assign start_query_signal = start_q;
  assign inst_valid_to_dispatch = ivalid_q;
  assign inst_to_dispatch = inst_q;
  assign pc_to_dispatch = dpc_q;
  // next state: clear redirects, IDLE serves hits or issues a miss, WAIT_MEM returns on finish
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    req_pc_d = req_pc_q;
    inst_d = inst_q;
    dpc_d = dpc_q;
    start_d = 1'b0;
    ivalid_d = 1'b0;
    if (clear_signal_from_rob) begin
      state_d = IDLE;
      pc_d = target_pc_from_rob;
    end else if (state_q == IDLE) begin
      if (!hit) begin
        start_d = 1'b1;
        req_pc_d = pc_q;
        state_d = WAIT_MEM;
      end else if (!stall_from_dispatch) begin
        ivalid_d = 1'b1;
        inst_d = data_q[idx];
        dpc_d = pc_q;
        pc_d = pc_q + 32'd4;
      end
    end else if (finish_query_signal) begin
      state_d = IDLE;
    end
  end
  // pipeline registers, frozen while rdy is low
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= '0;
      req_pc_q <= '0;
      inst_q <= '0;
      dpc_q <= '0;
      start_q <= 1'b0;
      ivalid_q <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
      inst_q <= inst_d;
      dpc_q <= dpc_d;
      start_q <= start_d;
      ivalid_q <= ivalid_d;
    end
  end
  // cache fill for the outstanding request, also taken when a clear lands on the finish cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (rdy && fill) begin
      valid_q[fill_idx] <= 1'b1;
      tag_q[fill_idx] <= req_pc_q[31:ICACHE_INDEX_BITS+2];
      data_q[fill_idx] <= inst_from_mem_ctrl;
    end
  end
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: random and directed fetch traffic checked against an address-level cache model
module tb_inst_fetcher;
  localparam int N = 16;
  logic clk = 1'b0;
  logic rst, rdy, start_query_signal, finish_query_signal, stall_from_dispatch;
  logic inst_valid_to_dispatch, clear_signal_from_rob;
  logic [31:0] pc_to_mem_ctrl, inst_from_mem_ctrl, inst_to_dispatch, pc_to_dispatch, target_pc_from_rob;
  always #5 clk = ~clk;
  inst_fetcher #(.ICACHE_INDEX_BITS(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .pc_to_mem_ctrl(pc_to_mem_ctrl), .start_query_signal(start_query_signal),
    .finish_query_signal(finish_query_signal), .inst_from_mem_ctrl(inst_from_mem_ctrl),
    .stall_from_dispatch(stall_from_dispatch), .inst_valid_to_dispatch(inst_valid_to_dispatch),
    .inst_to_dispatch(inst_to_dispatch), .pc_to_dispatch(pc_to_dispatch),
    .clear_signal_from_rob(clear_signal_from_rob), .target_pc_from_rob(target_pc_from_rob)
  );
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 0 ? 32'h00100093 : (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction
  logic [31:0] m_pc, m_req, c_addr [N], c_data [N];
  bit c_ok [N];
  bit m_wait;
  logic e_start, e_v;
  logic [31:0] e_mpc, e_inst, e_dpc;
  int cnt;
  logic [31:0] ctrl_addr;
  task automatic do_reset();
    rst = 1; rdy = 1; clear_signal_from_rob = 0; target_pc_from_rob = 0;
    stall_from_dispatch = 0; finish_query_signal = 0; inst_from_mem_ctrl = 0;
    @(posedge clk);
    m_pc = 0; m_req = 0; m_wait = 0; cnt = 0; ctrl_addr = 0;
    e_start = 0; e_v = 0; e_mpc = 0; e_inst = 0; e_dpc = 0;
    for (int i = 0; i < N; i++) c_ok[i] = 0;
    #1;
    chk("rst_start", start_query_signal, 0);
    chk("rst_mem_pc", pc_to_mem_ctrl, 0);
    chk("rst_valid", inst_valid_to_dispatch, 0);
    chk("rst_inst", inst_to_dispatch, 0);
    chk("rst_dpc", pc_to_dispatch, 0);
  endtask
  task automatic cycle(input bit clr, input logic [31:0] tgt, input bit stl, input bit rdy_v, input bit stale);
    bit fin, accept;
    logic [31:0] fi, req_now;
    int ix;
    fin = cnt == 1 || stale;
    fi = stale ? 32'hBAD00000 ^ $urandom : mem(ctrl_addr);
    rst = 0; rdy = rdy_v; clear_signal_from_rob = clr; target_pc_from_rob = tgt;
    stall_from_dispatch = stl; finish_query_signal = fin; inst_from_mem_ctrl = fi;
    accept = rdy_v && start_query_signal && !clr;
    req_now = pc_to_mem_ctrl;
    @(posedge clk);
    if (rdy_v) begin
      e_start = 0;
      e_v = 0;
      if (clr) begin
        m_pc = tgt;
      end else if (!m_wait) begin
        ix = (m_pc >> 2) % N;
        if (!(c_ok[ix] && c_addr[ix] == m_pc)) begin
          e_start = 1; e_mpc = m_pc; m_req = m_pc;
        end else if (!stl) begin
          e_v = 1; e_inst = c_data[ix]; e_dpc = m_pc; m_pc = m_pc + 4;
        end
      end
      if (m_wait && fin) begin
        ix = (m_req >> 2) % N;
        c_ok[ix] = 1; c_addr[ix] = m_req; c_data[ix] = fi;
      end
      m_wait = clr ? 0 : (m_wait ? !fin : e_start);
      if (cnt > 0) cnt--;
      if (clr) cnt = 0;
      if (accept) begin
        cnt = $urandom_range(3, 7);
        ctrl_addr = req_now;
      end
    end
    #1;
    chk("start", start_query_signal, e_start);
    chk("mem_pc", pc_to_mem_ctrl, e_mpc);
    chk("valid", inst_valid_to_dispatch, e_v);
    chk("inst", inst_to_dispatch, e_inst);
    chk("dpc", pc_to_dispatch, e_dpc);
  endtask
  task automatic tick();
    cycle(0, 0, 0, 1, 0);
  endtask
  task automatic redirect(input logic [31:0] t);
    cycle(1, t, 0, 1, 0);
  endtask
  task automatic wait_emit(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!inst_valid_to_dispatch && n < 40);
    chk(tag, inst_valid_to_dispatch, 1);
  endtask
  initial begin
    int n;
    do_reset();
    tick();
    chk("cold_req", start_query_signal, 1);
    chk("cold_req_pc", pc_to_mem_ctrl, 0);
    wait_emit("cold_emit");
    chk("cold_inst", inst_to_dispatch, 32'h00100093);
    chk("cold_pc", pc_to_dispatch, 0);
    tick();
    chk("req4", start_query_signal, 1);
    chk("req4_pc", pc_to_mem_ctrl, 4);
    n = 0;
    while (!(inst_valid_to_dispatch && pc_to_dispatch == 32'hC) && n < 200) begin
      tick();
      n++;
    end
    chk("preload", pc_to_dispatch, 32'hC);
    redirect(0);
    chk("clr_novalid", inst_valid_to_dispatch, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("warm_v", inst_valid_to_dispatch, 1);
      chk("warm_pc", pc_to_dispatch, i * 4);
    end
    redirect(8);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 1, 0);
      chk("stall_v", inst_valid_to_dispatch, 0);
    end
    tick();
    chk("unstall_v", inst_valid_to_dispatch, 1);
    chk("unstall_pc", pc_to_dispatch, 8);
    redirect(32'h20);
    tick();
    chk("miss20", pc_to_mem_ctrl, 32'h20);
    tick();
    redirect(32'h100);
    tick();
    chk("req100", start_query_signal, 1);
    chk("req100_pc", pc_to_mem_ctrl, 32'h100);
    wait_emit("emit100");
    chk("emit100_pc", pc_to_dispatch, 32'h100);
    redirect(32'h100);
    cycle(0, 0, 1, 1, 1);
    chk("stale_v", inst_valid_to_dispatch, 0);
    redirect(32'h20);
    tick();
    chk("stale_nofill", start_query_signal, 1);
    n = 0;
    while (cnt != 1 && n < 40) begin
      tick();
      n++;
    end
    chk("fin_pending", cnt, 1);
    redirect(32'h200);
    chk("coinc_v", inst_valid_to_dispatch, 0);
    tick();
    chk("coinc_pc", pc_to_mem_ctrl, 32'h200);
    redirect(32'h20);
    tick();
    chk("hit20_v", inst_valid_to_dispatch, 1);
    chk("hit20_inst", inst_to_dispatch, mem(32'h20));
    redirect(32'h40);
    wait_emit("emit40");
    redirect(0);
    tick();
    chk("evict_req", start_query_signal, 1);
    chk("evict_pc", pc_to_mem_ctrl, 0);
    for (int i = 0; i < 1500; i++) begin
      bit clr, stale;
      clr = $urandom_range(0, 99) < 6;
      stale = !m_wait && cnt == 0 && $urandom_range(0, 99) < 4;
      cycle(clr, ($urandom_range(0, 3) << 8) | ($urandom_range(0, 31) << 2),
            $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 90, stale);
    end
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
